// File: rtl/spi_master_mc_if.sv
// spi_master_mc_if: request, configuration and status bus plus the SPI pins of
// spi_master_mc. The loopback_i control exists only when SPI_MASTER_MC_LOOPBACK_EN
// is defined. The slave modport is the SPI master core; master is its requester.
interface spi_master_mc_if #(
  parameter int NUM_CS   = 4,
  parameter int MAX_WORD = 32,
  parameter int DIV_W    = 8,
  parameter int TIM_W    = 8
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int WL_W = $clog2(MAX_WORD);

  logic                start_i;
  logic                busy_o;
  logic                done_o;
  logic                err_o;
  logic [CS_W-1:0]     cs_sel_i;
  logic [1:0]          spi_mode_i;
  logic [DIV_W-1:0]    clk_div_i;
  logic [WL_W-1:0]     word_len_i;
  logic                lsb_first_i;
  logic [TIM_W-1:0]    t_IFG_i;
  logic [TIM_W-1:0]    t_CS_SCK_i;
  logic [TIM_W-1:0]    t_SCK_CS_i;
  logic [MAX_WORD-1:0] mosi_data_i;
  logic [MAX_WORD-1:0] miso_data_o;
  logic                MISO_i;
  logic                MOSI_o;
  logic                SCLK_o;
  logic [NUM_CS-1:0]   CS_o;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
  logic                loopback_i;
`endif

  modport slave (
`ifdef SPI_MASTER_MC_LOOPBACK_EN
    input  loopback_i,
`endif
    input  start_i, cs_sel_i, spi_mode_i, clk_div_i, word_len_i, lsb_first_i,
    input  t_IFG_i, t_CS_SCK_i, t_SCK_CS_i, mosi_data_i, MISO_i,
    output busy_o, done_o, err_o, miso_data_o, MOSI_o, SCLK_o, CS_o
  );

  modport master (
`ifdef SPI_MASTER_MC_LOOPBACK_EN
    output loopback_i,
`endif
    output start_i, cs_sel_i, spi_mode_i, clk_div_i, word_len_i, lsb_first_i,
    output t_IFG_i, t_CS_SCK_i, t_SCK_CS_i, mosi_data_i, MISO_i,
    input  busy_o, done_o, err_o, miso_data_o, MOSI_o, SCLK_o, CS_o
  );
endinterface

// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-chip-select SPI master with runtime word length, SCLK
// divider, bit order and CS lead/trail/inter-frame timing.
// Optional feature macro: SPI_MASTER_MC_LOOPBACK_EN (internal MOSI->sample loopback).
module spi_master_mc #(
  parameter int NUM_CS   = 4,
  parameter int MAX_WORD = 32,
  parameter int DIV_W    = 8,
  parameter int TIM_W    = 8
) (
  input  logic           GCLK,
  input  logic           RST_N,
  spi_master_mc_if.slave bus
);
  localparam int              CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int              WL_W     = $clog2(MAX_WORD);
  localparam logic [CS_W:0]   NUM_CS_V = (CS_W + 1)'(NUM_CS);

  typedef enum logic [2:0] {ST_IDLE, ST_LEAD, ST_XFER, ST_TRAIL, ST_GAP} state_e;
  state_e state_q, state_d;

  logic [TIM_W-1:0]    cnt_q, cnt_d, lead_q, lead_d, trail_q, trail_d, ifg_q, ifg_d;
  logic [DIV_W-1:0]    hp_q, hp_d, div_q, div_d;
  logic [WL_W:0]       sck_cnt_q, sck_cnt_d;
  logic [WL_W-1:0]     wl_q, wl_d;
  logic                lsb_q, lsb_d, cpha_q, cpha_d;
  logic [MAX_WORD-1:0] tx_q, tx_d, rx_q, rx_d, miso_q, miso_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d, err_q, err_d;

  logic            sel_ok, accept, reject, hp_end, last_edge, lead_end, trail_end, gap_end;
  logic            leading, sample_now, drive_now, sample_bit;
  logic [WL_W-1:0] bit_j, drive_j, sample_pos, drive_pos, first_pos;

  // Edge k (1..2N) retires at the end of half-period k; sck_cnt_q counts retired
  // edges, so bit index j = sck_cnt_q/2 serves both sampling and driving.
  assign sel_ok     = ({1'b0, bus.cs_sel_i} < NUM_CS_V);
  assign accept     = (state_q == ST_IDLE) && bus.start_i && sel_ok;
  assign reject     = (state_q == ST_IDLE) && bus.start_i && !sel_ok;
  assign hp_end     = (hp_q == div_q - DIV_W'(1));
  assign last_edge  = (sck_cnt_q == {wl_q, 1'b1});
  assign lead_end   = (cnt_q == lead_q);
  assign trail_end  = (cnt_q == trail_q);
  assign gap_end    = (cnt_q == ifg_q - TIM_W'(1));
  assign leading    = ~sck_cnt_q[0];
  assign sample_now = leading ^ cpha_q;
  assign drive_now  = ~sample_now & ~last_edge;
  assign bit_j      = sck_cnt_q[WL_W:1];
  assign drive_j    = cpha_q ? bit_j : bit_j + WL_W'(1);
  assign sample_pos = lsb_q ? bit_j : wl_q - bit_j;
  assign drive_pos  = lsb_q ? drive_j : wl_q - drive_j;
  assign first_pos  = bus.lsb_first_i ? '0 : bus.word_len_i;

`ifdef SPI_MASTER_MC_LOOPBACK_EN
  logic lb_q, lb_d;
  assign sample_bit = lb_q ? mosi_q : bus.MISO_i;
`else
  assign sample_bit = bus.MISO_i;
`endif

  // State and datapath registers, asynchronous active-low reset.
  always_ff @(posedge GCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lead_q    <= '0;
      trail_q   <= '0;
      ifg_q     <= '0;
      hp_q      <= '0;
      div_q     <= DIV_W'(1);
      sck_cnt_q <= '0;
      wl_q      <= '0;
      lsb_q     <= 1'b0;
      cpha_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      miso_q    <= '0;
      cs_n_q    <= '1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
      lb_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lead_q    <= lead_d;
      trail_q   <= trail_d;
      ifg_q     <= ifg_d;
      hp_q      <= hp_d;
      div_q     <= div_d;
      sck_cnt_q <= sck_cnt_d;
      wl_q      <= wl_d;
      lsb_q     <= lsb_d;
      cpha_q    <= cpha_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      miso_q    <= miso_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
      lb_q      <= lb_d;
`endif
    end
  end

  // Next-state logic: IDLE -> LEAD -> XFER -> TRAIL -> (GAP) -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LEAD;
      ST_LEAD:  if (lead_end) state_d = ST_XFER;
      ST_XFER:  if (hp_end && last_edge) state_d = ST_TRAIL;
      ST_TRAIL: if (trail_end) state_d = (ifg_q == '0) ? ST_IDLE : ST_GAP;
      ST_GAP:   if (gap_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs: config latch, SCLK/MOSI generation, sampling.
  always_comb begin
    lead_d    = lead_q;
    trail_d   = trail_q;
    ifg_d     = ifg_q;
    hp_d      = hp_q;
    div_d     = div_q;
    sck_cnt_d = sck_cnt_q;
    wl_d      = wl_q;
    lsb_d     = lsb_q;
    cpha_d    = cpha_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    miso_d    = miso_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
    lb_d      = lb_q;
`endif
    cnt_d = (state_d == state_q && state_q != ST_IDLE) ? cnt_q + TIM_W'(1) : '0;
    case (state_q)
      ST_IDLE: begin
        sclk_d = bus.spi_mode_i[1];
        mosi_d = 1'b0;
        err_d  = reject;
        if (accept) begin
          lead_d    = bus.t_CS_SCK_i;
          trail_d   = bus.t_SCK_CS_i;
          ifg_d     = bus.t_IFG_i;
          div_d     = (bus.clk_div_i == '0) ? DIV_W'(1) : bus.clk_div_i;
          wl_d      = bus.word_len_i;
          lsb_d     = bus.lsb_first_i;
          cpha_d    = bus.spi_mode_i[0];
          tx_d      = bus.mosi_data_i;
          rx_d      = '0;
          hp_d      = '0;
          sck_cnt_d = '0;
          cs_n_d    = ~(NUM_CS'(1) << bus.cs_sel_i);
          mosi_d    = bus.spi_mode_i[0] ? 1'b0 : bus.mosi_data_i[first_pos];
`ifdef SPI_MASTER_MC_LOOPBACK_EN
          lb_d      = bus.loopback_i;
`endif
        end
      end
      ST_XFER: begin
        if (hp_end) begin
          hp_d      = '0;
          sclk_d    = ~sclk_q;
          sck_cnt_d = sck_cnt_q + (WL_W + 1)'(1);
          if (sample_now) rx_d[sample_pos] = sample_bit;
          if (drive_now) mosi_d = tx_q[drive_pos];
        end else begin
          hp_d = hp_q + DIV_W'(1);
        end
      end
      ST_TRAIL: begin
        if (trail_end) begin
          cs_n_d = '1;
          done_d = 1'b1;
          miso_d = rx_q;
          mosi_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.miso_data_o = miso_q;
  assign bus.MOSI_o      = mosi_q;
  assign bus.SCLK_o      = sclk_q;
  assign bus.CS_o        = cs_n_q;
endmodule
